// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 key path.
package chacha_pkg;

  localparam int KEY_WORDS  = 8;
  localparam int WORD_W     = 32;
  localparam int FAIL_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/entropy_key_loader_rep_count_test.sv
// Online repetition-count health test: tracks the run of identical bits within
// one word and flags the word once any run reaches REP_LIMIT.
module rep_count_test #(
  parameter int REP_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic valid,
  input  logic bit_in,
  output logic fail
);

  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  logic [RUN_W-1:0] run_q, run_d, run_now;
  logic             prev_q, prev_d;
  logic             fail_q, fail_d;
  logic             hit_now;

  // Run length including the bit presented this cycle, and whether it hits the limit.
  // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    run_now = run_q;
    hit_now = 1'b0;
    if (valid) begin
      if ((run_q != '0) && (bit_in == prev_q)) begin
        run_now = (run_q == RUN_W'(REP_LIMIT)) ? run_q : run_q + 1'b1;
      end else begin
        run_now = RUN_W'(1);
      end
      hit_now = (run_now == RUN_W'(REP_LIMIT));
    end
  end

  // Next state; clear starts a fresh word and overrides the update.
  always_comb begin
    run_d  = run_now;
    prev_d = valid ? bit_in : prev_q;
    fail_d = fail_q | hit_now;
    if (clear) begin
      run_d  = '0;
      prev_d = 1'b0;
      fail_d = 1'b0;
    end
  end

  // The completing bit of a word must count, so the verdict includes this cycle's hit.
  assign fail = fail_q | hit_now;

  // Run-counter registers.
  // NOTE: clocked blocks use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= '0;
      prev_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      prev_q <= prev_d;
      fail_q <= fail_d;
    end
  end

endmodule

// File: rtl/entropy_key_loader.sv
// Entropy-to-key loader: assembles TRNG bits into words, screens each word with
// the repetition-count test and writes NUM_WORDS accepted words to the key file.
module entropy_key_loader #(
  parameter  int WORD_W    = chacha_pkg::WORD_W,
  parameter  int NUM_WORDS = chacha_pkg::KEY_WORDS,
  parameter  int REP_LIMIT = 16,
  parameter  int MAX_FAILS = 4,
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ent_bit,
  input  logic              ent_valid,
  output logic              key_we,
  input  logic              key_ready,
  output logic [IDX_W-1:0]  key_idx,
  output logic [WORD_W-1:0] key_word,
  output logic              busy,
  output logic              done,
  output logic              health_fail,
  output logic [7:0]        fail_cnt
);

  import chacha_pkg::*;

  localparam int CNT_W = $clog2(WORD_W);
  localparam int CF_W  = $clog2(MAX_FAILS + 1);

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [CF_W-1:0]         consec_q, consec_d;
  logic                    done_q, done_d;
  logic                    hf_q, hf_d;

  logic bit_take, word_end, word_fail, accept, reject, last_reject;
  logic handshake, last_word, restart, rct_clear;

  assign bit_take    = (state_q == ST_COLLECT) && ent_valid;
  assign word_end    = bit_take && (bit_cnt_q == CNT_W'(WORD_W - 1));
  assign accept      = word_end && !word_fail;
  assign reject      = word_end && word_fail;
  assign last_reject = reject && (consec_q == CF_W'(MAX_FAILS - 1));
  assign handshake   = (state_q == ST_WRITE) && key_ready;
  assign last_word   = (idx_q == IDX_W'(NUM_WORDS - 1));
  assign restart     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERROR));
  assign rct_clear   = word_end || restart;

  rep_count_test #(
    .REP_LIMIT (REP_LIMIT)
  ) u_rct (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rct_clear),
    .valid  (bit_take),
    .bit_in (ent_bit),
    .fail   (word_fail)
  );

  // Next-state logic; start is only honoured outside an active load.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (accept)           state_d = ST_WRITE;
        else if (last_reject) state_d = ST_ERROR;
      end
      ST_WRITE:   if (handshake) state_d = last_word ? ST_DONE : ST_COLLECT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath: shift register, bit/word counters and sticky status.
  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    fail_cnt_d = fail_cnt_q;
    consec_d   = consec_q;
    done_d     = done_q;
    hf_d       = hf_q;

    if (restart) begin
      bit_cnt_d  = '0;
      idx_d      = '0;
      fail_cnt_d = '0;
      consec_d   = '0;
      done_d     = 1'b0;
      hf_d       = 1'b0;
    end

    if (bit_take) begin
      shreg_d   = {shreg_q[WORD_W-2:0], ent_bit};
      bit_cnt_d = word_end ? '0 : bit_cnt_q + 1'b1;
    end

    if (reject) begin
      fail_cnt_d = sat_inc(fail_cnt_q);
      consec_d   = consec_q + 1'b1;
    end
    if (last_reject) hf_d = 1'b1;
    if (accept)      consec_d = '0;

    if (handshake) begin
      if (last_word) done_d = 1'b1;
      else           idx_d  = idx_q + 1'b1;
    end
  end

  // Moore outputs; key_word is only driven while a write is offered.
  always_comb begin
    key_we   = (state_q == ST_WRITE);
    key_word = (state_q == ST_WRITE) ? shreg_q : '0;
    busy     = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  end

  assign key_idx     = idx_q;
  assign done        = done_q;
  assign health_fail = hf_q;
  assign fail_cnt    = fail_cnt_q;

  // State and datapath registers.
  // NOTE: the shift register is reset too, so a partial word of old entropy never survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      fail_cnt_q <= '0;
      consec_q   <= '0;
      done_q     <= 1'b0;
      hf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      fail_cnt_q <= fail_cnt_d;
      consec_q   <= consec_d;
      done_q     <= done_d;
      hf_q       <= hf_d;
    end
  end

endmodule

// File: tb/tb_entropy_key_loader.sv
// Self-checking bench for entropy_key_loader: a word-level model checked every
// cycle for the default build, plus directed checks on a 4x16-bit build.
module tb_entropy_key_loader;

  localparam int P_IDLE = 0, P_COLLECT = 1, P_WRITE = 2, P_DONE = 3, P_ERROR = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, ent_bit = 1'b0, ent_valid = 1'b0;
  logic        key_ready = 1'b1;
  logic        key_we, busy, done, health_fail;
  logic [2:0]  key_idx;
  logic [31:0] key_word;
  logic [7:0]  fail_cnt;

  logic        start2 = 1'b0, ent_bit2 = 1'b0, ent_valid2 = 1'b0;
  logic        key_ready2 = 1'b1;
  logic        key_we2, busy2, done2, health_fail2;
  logic [1:0]  key_idx2;
  logic [15:0] key_word2;
  logic [7:0]  fail_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  entropy_key_loader dut (
    .clk (clk), .rst_n (rst_n), .start (start), .ent_bit (ent_bit), .ent_valid (ent_valid),
    .key_we (key_we), .key_ready (key_ready), .key_idx (key_idx), .key_word (key_word),
    .busy (busy), .done (done), .health_fail (health_fail), .fail_cnt (fail_cnt)
  );

  entropy_key_loader #(.WORD_W(16), .NUM_WORDS(4)) dut2 (
    .clk (clk), .rst_n (rst_n), .start (start2), .ent_bit (ent_bit2), .ent_valid (ent_valid2),
    .key_we (key_we2), .key_ready (key_ready2), .key_idx (key_idx2), .key_word (key_word2),
    .busy (busy2), .done (done2), .health_fail (health_fail2), .fail_cnt (fail_cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- word-level reference model (default build) ----------------
  int          m_phase = P_IDLE;
  logic [31:0] m_word = '0;
  int          m_nbits = 0, m_idx = 0, m_fails = 0, m_consec = 0;
  logic        m_done = 1'b0, m_hf = 1'b0;

  function automatic int longest_run(input logic [31:0] w);
    int best = 1;
    int cur  = 1;
    for (int i = 1; i < 32; i++) begin
      cur = (w[i] == w[i-1]) ? cur + 1 : 1;
      if (cur > best) best = cur;
    end
    return best;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_IDLE; m_word = '0; m_nbits = 0; m_idx = 0;
      m_fails = 0; m_consec = 0; m_done = 1'b0; m_hf = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE, P_ERROR: if (start) begin
          m_phase = P_COLLECT; m_nbits = 0; m_idx = 0;
          m_fails = 0; m_consec = 0; m_done = 1'b0; m_hf = 1'b0;
        end
        P_COLLECT: if (ent_valid) begin
          m_word = {m_word[30:0], ent_bit};
          m_nbits++;
          if (m_nbits == 32) begin
            m_nbits = 0;
            if (longest_run(m_word) >= 16) begin
              if (m_fails < 255) m_fails++;
              m_consec++;
              if (m_consec == 4) begin m_phase = P_ERROR; m_hf = 1'b1; end
            end else begin
              m_consec = 0;
              m_phase  = P_WRITE;
            end
          end
        end
        P_WRITE: if (key_ready) begin
          if (m_idx == 7) begin m_phase = P_DONE; m_done = 1'b1; end
          else begin m_idx++; m_phase = P_COLLECT; end
        end
        default: ;
      endcase
    end
  end

  // key_ready stalls for stall_left cycles while the model offers word stall_idx.
  int stall_idx = -1;
  int stall_left = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (m_phase == P_WRITE && m_idx == stall_idx && stall_left > 0) begin
      key_ready = 1'b0;
      stall_left--;
    end else begin
      key_ready = 1'b1;
    end
  end

  // ---------------- compare process and write logs ----------------
  int          we_cycles = 0, stall_seen = 0;
  int          log_idx[$];
  logic [31:0] log_word[$];
  int          log2_idx[$];
  logic [15:0] log2_word[$];

  initial forever begin
    logic [46:0] exp_v, act_v;
    @(negedge clk);
    exp_v = {m_phase == P_WRITE, 3'(m_idx), (m_phase == P_WRITE) ? m_word : 32'h0,
             (m_phase == P_COLLECT) || (m_phase == P_WRITE), m_done, m_hf, 8'(m_fails)};
    act_v = {key_we, key_idx, key_word, busy, done, health_fail, fail_cnt};
    check("cycle_outputs", act_v, exp_v);
    if (key_we) we_cycles++;
    if (key_we && !key_ready) stall_seen++;
    if (key_we && key_ready) begin
      log_idx.push_back(int'(key_idx));
      log_word.push_back(key_word);
    end
    if (key_we2 && key_ready2) begin
      log2_idx.push_back(int'(key_idx2));
      log2_word.push_back(key_word2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed_bit(input logic b);
    int n = 0;
    while (m_phase != P_COLLECT && n < 200) begin tick(); n++; end
    if (n == 200) check("feed_wait_collect", m_phase, P_COLLECT);
    ent_valid = 1'b1;
    ent_bit   = b;
    tick();
    ent_valid = 1'b0;
    ent_bit   = 1'b0;
  endtask

  task automatic feed_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) feed_bit(w[i]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    check(name, done, 1'b1);
  endtask

  task automatic feed_word2(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      ent_valid2 = 1'b1;
      ent_bit2   = w[i];
      tick();
      ent_valid2 = 1'b0;
      repeat (3) tick();
    end
  endtask

  // Global safety net.
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int b, w0, s0;
    logic [15:0] exp2 [4];
    exp2[0] = 16'hC3A5; exp2[1] = 16'h0F0F; exp2[2] = 16'h1234; exp2[3] = 16'hFFFE;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_key_we", key_we, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_fail_cnt", fail_cnt, 8'd0);

    // 1: clean alternating stream; a start during the last write is ignored.
    b = log_word.size();
    pulse_start();
    for (int w = 0; w < 8; w++) feed_word(32'hAAAAAAAA);
    pulse_start();
    check("t1_writes", log_word.size() - b, 8);
    for (int i = 0; i < 8; i++) begin
      check("t1_idx", log_idx[b+i], i);
      check("t1_word", log_word[b+i], 32'hAAAAAAAA);
    end
    check("t1_done", done, 1'b1);
    check("t1_busy", busy, 1'b0);
    check("t1_fail_cnt", fail_cnt, 8'd0);
    check("t1_idx_held", key_idx, 3'd7);

    // 2: key_ready stalls for 5 cycles on idx 3.
    b = log_word.size(); w0 = we_cycles; s0 = stall_seen;
    stall_idx = 3; stall_left = 5;
    pulse_start();
    for (int w = 0; w < 8; w++) feed_word(32'hAAAAAAAA);
    wait_done("t2_done");
    check("t2_writes", log_word.size() - b, 8);
    check("t2_stalls", stall_seen - s0, 5);
    check("t2_we_cycles", we_cycles - w0, 13);
    check("t2_idx3", log_idx[b+3], 3);
    check("t2_word3", log_word[b+3], 32'hAAAAAAAA);

    // 3: a run of 16 ones rejects word 2; a run of 15 passes; mid-load start ignored.
    b = log_word.size();
    pulse_start();
    feed_word(32'hAAAAAAAA);
    feed_word(32'hAAAAAAAA);
    feed_word(32'hAAFFFF55);
    check("t3_fail_cnt_1", fail_cnt, 8'd1);
    pulse_start();
    check("t3_start_ignored", busy, 1'b1);
    feed_word(32'hAAAAAAAA);
    feed_word(32'hAAAAAAAA);
    feed_word(32'hAAFFFEAA);
    for (int w = 0; w < 3; w++) feed_word(32'hAAAAAAAA);
    wait_done("t3_done");
    check("t3_writes", log_word.size() - b, 8);
    check("t3_idx_after_reject", log_idx[b+2], 2);
    check("t3_word_after_reject", log_word[b+2], 32'hAAAAAAAA);
    check("t3_run15_word", log_word[b+4], 32'hAAFFFEAA);
    check("t3_fail_cnt", fail_cnt, 8'd1);

    // 4: constant zeros -> four rejects, ERROR, never a write.
    w0 = we_cycles;
    pulse_start();
    for (int w = 0; w < 3; w++) feed_word(32'h0);
    check("t4_hf_before", health_fail, 1'b0);
    check("t4_fail_cnt_3", fail_cnt, 8'd3);
    feed_word(32'h0);
    check("t4_health_fail", health_fail, 1'b1);
    check("t4_fail_cnt_4", fail_cnt, 8'd4);
    check("t4_busy", busy, 1'b0);
    ent_valid = 1'b1;
    repeat (40) tick();
    ent_valid = 1'b0;
    check("t4_no_writes", we_cycles - w0, 0);

    // 5: restart from ERROR, then reset after idx 4 is written.
    pulse_start();
    check("t5_hf_cleared", health_fail, 1'b0);
    check("t5_fail_cnt_cleared", fail_cnt, 8'd0);
    b = log_word.size();
    for (int w = 0; w < 5; w++) feed_word(32'hAAAAAAAA);
    tick();
    check("t5_pre_reset_writes", log_word.size() - b, 5);
    for (int i = 0; i < 10; i++) feed_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_key_we", key_we, 1'b0);
    check("t5_rst_idx", key_idx, 3'd0);
    check("t5_rst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    b = log_word.size();
    pulse_start();
    feed_word(32'hAAAAAAAA);
    tick();
    check("t5_rewrite_count", log_word.size() - b, 1);
    check("t5_rewrite_idx", log_idx[b], 0);

    // 6: 4x16 build, 25% ent_valid duty.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int w = 0; w < 4; w++) feed_word2(exp2[w]);
    repeat (4) tick();
    check("t6_writes", log2_word.size(), 4);
    for (int i = 0; i < 4 && i < log2_word.size(); i++) begin
      check("t6_idx", log2_idx[i], i);
      check("t6_word", log2_word[i], exp2[i]);
    end
    check("t6_done", done2, 1'b1);
    check("t6_busy", busy2, 1'b0);
    check("t6_fail_cnt", fail_cnt2, 8'd0);
    check("t6_hf", health_fail2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
